receptor_serie_32: RTL and testbench



---
 rtl/receptor_serie_32.sv | 138 +++++++++++++
 tb/tb_receptor_serie_32.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/receptor_serie_32.sv
// Framed serial receiver: start(0) + ANCHO data bits + stop(1), parallel word with VALIDO/ERROR pulses.
// Optional even-parity bit between data and stop when RECEPTOR_PARIDAD_EN is defined.
module receptor_serie_32 #(
  parameter int ANCHO = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENB,
  input  logic             DIR,
  input  logic             S_IN,
  output logic [ANCHO-1:0] Q,
  output logic             VALIDO,
  output logic             OCUPADO,
  output logic             ERROR
);

`ifdef RECEPTOR_PARIDAD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATOS = 2'd1, PARIDAD = 2'd2, PARADA = 2'd3} estado_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATOS = 2'd1, PARADA = 2'd3} estado_t;
`endif

  estado_t             estado_q, estado_d;
  logic                armado_q, armado_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ANCHO-1:0]    sh_q, sh_d;
  logic                dir_q, dir_d;
  logic [ANCHO-1:0]    q_q, q_d;
  logic                valido_q, valido_d;
  logic                error_q, error_d;
  logic                ocupado_q, ocupado_d;
  logic                par_err_q, par_err_d;

  // Next-state and output decode; pulses default low, everything else holds unless sampled.
  always_comb begin
    estado_d  = estado_q;
    armado_d  = armado_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    dir_d     = dir_q;
    q_d       = q_q;
    valido_d  = 1'b0;
    error_d   = 1'b0;
    par_err_d = par_err_q;
    if (ENB) begin
      case (estado_q)
        IDLE: begin
          if (S_IN) begin
            armado_d = 1'b1;
          end else if (armado_q) begin
            dir_d     = DIR;
            cnt_d     = {CNT_W{1'b0}};
            sh_d      = {ANCHO{1'b0}};
            par_err_d = 1'b0;
            estado_d  = DATOS;
          end else begin
            armado_d = 1'b0;
          end
        end
        DATOS: begin
          // MSB-first shifts toward the top so the first bit lands in Q[ANCHO-1].
          if (dir_q) begin
            sh_d = {sh_q[ANCHO-2:0], S_IN};
          end else begin
            sh_d = {S_IN, sh_q[ANCHO-1:1]};
          end
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_W'(ANCHO - 1)) begin
`ifdef RECEPTOR_PARIDAD_EN
            estado_d = PARIDAD;
`else
            estado_d = PARADA;
`endif
          end else begin
            estado_d = DATOS;
          end
        end
`ifdef RECEPTOR_PARIDAD_EN
        PARIDAD: begin
          par_err_d = (^sh_q) ^ S_IN;
          estado_d  = PARADA;
        end
`endif
        PARADA: begin
          estado_d = IDLE;
          armado_d = S_IN;
          if (S_IN && !par_err_q) begin
            q_d      = sh_q;
            valido_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        default: begin
          estado_d = IDLE;
          armado_d = 1'b0;
        end
      endcase
    end else begin
      estado_d = estado_q;
    end
    ocupado_d = (estado_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      estado_q  <= IDLE;
      armado_q  <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
      sh_q      <= {ANCHO{1'b0}};
      dir_q     <= 1'b0;
      q_q       <= {ANCHO{1'b0}};
      valido_q  <= 1'b0;
      error_q   <= 1'b0;
      ocupado_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      armado_q  <= armado_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      dir_q     <= dir_d;
      q_q       <= q_d;
      valido_q  <= valido_d;
      error_q   <= error_d;
      ocupado_q <= ocupado_d;
      par_err_q <= par_err_d;
    end
  end

  assign Q       = q_q;
  assign VALIDO  = valido_q;
  assign ERROR   = error_q;
  assign OCUPADO = ocupado_q;

endmodule

// File: tb/tb_receptor_serie_32.sv
// Self-checking bench for receptor_serie_32: directed test-plan frames plus random frames.
// Expected words come from the frame the bench itself serialises.
module tb_receptor_serie_32;
  logic        CLK = 1'b0;
  logic        RST, ENB, DIR, S_IN;
  logic [31:0] Q;
  logic        VALIDO, OCUPADO, ERROR;

  receptor_serie_32 #(.ANCHO(32), .CNT_W(6)) dut (
    .CLK(CLK), .RST(RST), .ENB(ENB), .DIR(DIR), .S_IN(S_IN),
    .Q(Q), .VALIDO(VALIDO), .OCUPADO(OCUPADO), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

`ifdef RECEPTOR_PARIDAD_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  int          n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0, t_valid = 0, t0 = 0;
  logic [31:0] exp_q = 32'd0;

  task automatic tick;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic gap(input bit gated);
    if (gated) begin
      ENB = 1'b0;
      tick();
      chk("gap_valido", 32'(VALIDO), 32'd0);
      chk("gap_error", 32'(ERROR), 32'd0);
      ENB = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    S_IN = 1'b1;
    repeat (n) begin
      tick();
      chk("idle_ocupado", 32'(OCUPADO), 32'd0);
      chk("idle_valido", 32'(VALIDO), 32'd0);
    end
  endtask

  task automatic send_frame(input logic [31:0] w, input bit msb, input bit stop,
                            input bit pflip, input bit gated);
    bit ok;
    ok   = stop && !(PB == 1 && pflip);
    DIR  = msb;
    S_IN = 1'b0;
    tick();
    chk("start_ocupado", 32'(OCUPADO), 32'd1);
    chk("start_valido", 32'(VALIDO), 32'd0);
    gap(gated);
    for (int i = 0; i < 32; i++) begin
      S_IN = msb ? w[31-i] : w[i];
      DIR  = 1'($urandom);
      tick();
      chk("data_ocupado", 32'(OCUPADO), 32'd1);
      gap(gated);
    end
`ifdef RECEPTOR_PARIDAD_EN
    S_IN = (^w) ^ pflip;
    tick();
    chk("par_ocupado", 32'(OCUPADO), 32'd1);
    gap(gated);
`endif
    S_IN = stop;
    tick();
    if (ok) begin
      exp_q   = w;
      t_valid = cyc;
    end
    chk("stop_valido", 32'(VALIDO), 32'(ok));
    chk("stop_error", 32'(ERROR), 32'(!ok));
    chk("stop_q", Q, exp_q);
    chk("stop_ocupado", 32'(OCUPADO), 32'd0);
    gap(gated);
  endtask

  initial begin
    bit          msb, stop, pflip;
    logic [31:0] w;
    ENB = 1'b1; RST = 1'b1; DIR = 1'b1; S_IN = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_q", Q, 32'd0);
    chk("rst_valido", 32'(VALIDO), 32'd0);
    chk("rst_ocupado", 32'(OCUPADO), 32'd0);
    chk("rst_error", 32'(ERROR), 32'd0);
    idle(2);

    send_frame(32'hA5A50F0F, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);

    send_frame(32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0);
    t0 = t_valid;
    send_frame(32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("b2b_spacing", 32'(t_valid - t0), 32'(34 + PB));
    idle(1);

    send_frame(32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    S_IN = 1'b0;
    repeat (50) begin
      tick();
      chk("stuck_ocupado", 32'(OCUPADO), 32'd0);
      chk("stuck_error", 32'(ERROR), 32'd0);
      chk("stuck_q", Q, 32'h12345678);
    end
    idle(2);

    send_frame(32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1);

    w = 32'hCAFEBABE;
    DIR = 1'b1; S_IN = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      S_IN = w[31-i];
      tick();
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp_q = 32'd0;
    chk("mid_rst_q", Q, 32'd0);
    chk("mid_rst_ocupado", 32'(OCUPADO), 32'd0);
    chk("mid_rst_valido", 32'(VALIDO), 32'd0);
    S_IN = 1'b0;
    repeat (5) begin
      tick();
      chk("post_rst_ocupado", 32'(OCUPADO), 32'd0);
    end
    idle(2);
    send_frame(32'h00000055, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);

`ifdef RECEPTOR_PARIDAD_EN
    send_frame(32'h00000003, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(32'h00000003, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
`endif

    for (int k = 0; k < 8; k++) begin
      w     = $urandom;
      msb   = 1'($urandom);
      stop  = ($urandom_range(0, 3) != 0);
      pflip = ($urandom_range(0, 3) == 0);
      send_frame(w, msb, stop, pflip, (k == 5));
      if (!stop) idle(1 + int'($urandom_range(0, 2)));
      else idle(int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
